// File: rtl/encoder_4x2_seq.sv
// Sequential priority encoder.
// Captures a request vector through a valid/ready handshake, then emits the
// binary index of every set bit, highest index first, one code per transfer.
module encoder_4x2_seq #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] code,
    output logic         code_valid,
    input  logic         code_ready,
    output logic         code_last,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [N-1:0] pending, pending_nxt;
    logic [N-1:0] remainder;
    logic [W-1:0] code_nxt;
    logic         code_valid_nxt;
    logic         code_last_nxt;

    // Index of the highest set bit; later (higher) hits overwrite earlier ones.
    function automatic logic [W-1:0] top_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = W'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state == DRAIN);

    // State, pending vector and registered code outputs; reset discards any in-flight vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            code_last  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            code       <= code_nxt;
            code_valid <= code_valid_nxt;
            code_last  <= code_last_nxt;
        end
    end

    // Next-state logic: capture in IDLE, retire one bit per transfer in DRAIN.
    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        code_nxt       = code;
        code_valid_nxt = code_valid;
        code_last_nxt  = code_last;
        remainder      = pending & ~(N'(1) << code);

        case (state)
            IDLE: begin
                // A zero vector is accepted and dropped: nothing changes.
                if (req_valid && (req != '0)) begin
                    pending_nxt    = req;
                    code_nxt       = top_idx(req);
                    code_valid_nxt = 1'b1;
                    code_last_nxt  = is_single(req);
                    state_nxt      = DRAIN;
                end
            end
            DRAIN: begin
                if (code_valid && code_ready) begin
                    pending_nxt = remainder;
                    if (remainder != '0) begin
                        code_nxt      = top_idx(remainder);
                        code_last_nxt = is_single(remainder);
                    end else begin
                        code_valid_nxt = 1'b0;
                        code_last_nxt  = 1'b0;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Testbench for encoder_4x2_seq: directed scenarios plus randomized vectors
// checked against a queue-based model of the expected code sequence.
module tb_encoder_4x2_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] code;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic       code_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    encoder_4x2_seq #(.N(4), .W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_last  (code_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: indices of set bits, highest first.
    function automatic void expected_codes(input logic [3:0] v, output int q[$]);
        q = {};
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) q.push_back(i);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_code_valid got %0b want 0", code_valid); end
        checks++; if (code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (code_last !== 1'b0) begin errors++; $display("FAIL reset_code_last got %0b want 0", code_last); end
        #3 rst_n = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_single_bit();
        req = 4'b0100; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (code !== 2'd2) begin errors++; $display("FAIL single_code got %0d want 2", code); end
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", code_valid); end
        checks++; if (code_last !== 1'b1) begin errors++; $display("FAIL single_last got %0b want 1", code_last); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL single_req_ready got %0b want 0", req_ready); end
        step();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %0b want 0", code_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_full_vector();
        req = 4'b1111; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            checks++; if (code !== 2'(k)) begin errors++; $display("FAIL full_code got %0d want %0d", code, k); end
            checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %0b want 1 at code %0d", code_valid, k); end
            checks++; if (code_last !== (k == 0)) begin errors++; $display("FAIL full_last got %0b want %0b at code %0d", code_last, (k == 0), k); end
            step();
        end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL full_end_valid got %0b want 0", code_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_end_busy got %0b want 0", busy); end
    endtask

    task automatic test_backpressure();
        req = 4'b1010; req_valid = 1'b1; code_ready = 1'b0;
        step();
        req_valid = 1'b0;
        repeat (3) begin
            checks++; if (code !== 2'd3) begin errors++; $display("FAIL bp_hold_code got %0d want 3", code); end
            checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0b want 1", code_valid); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready got %0b want 0", req_ready); end
            checks++; if (code_last !== 1'b0) begin errors++; $display("FAIL bp_hold_last got %0b want 0", code_last); end
            step();
        end
        code_ready = 1'b1;
        checks++; if (code !== 2'd3) begin errors++; $display("FAIL bp_first_code got %0d want 3", code); end
        step();
        checks++; if (code !== 2'd1) begin errors++; $display("FAIL bp_second_code got %0d want 1", code); end
        checks++; if (code_last !== 1'b1) begin errors++; $display("FAIL bp_second_last got %0b want 1", code_last); end
        step();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b want 0", code_valid); end
    endtask

    task automatic test_zero_vector();
        req = 4'b0000; req_valid = 1'b1; code_ready = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_before got %0b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %0b want 0", code_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after got %0b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid_drain();
        req = 4'b0111; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (code !== 2'd2) begin errors++; $display("FAIL mid_first_code got %0d want 2", code); end
        step();
        code_ready = 1'b0;
        checks++; if (code !== 2'd1) begin errors++; $display("FAIL mid_second_code got %0d want 1", code); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0b want 0", code_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
        checks++; if (code !== 2'd0) begin errors++; $display("FAIL mid_rst_code got %0d want 0", code); end
        step();
        rst_n = 1'b1;
        code_ready = 1'b1;
        step();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %0b want 0", code_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %0b want 1", req_ready); end
        req = 4'b0001; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        checks++; if (code !== 2'd0) begin errors++; $display("FAIL mid_new_code got %0d want 0", code); end
        checks++; if (code_last !== 1'b1) begin errors++; $display("FAIL mid_new_last got %0b want 1", code_last); end
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %0b want 1", code_valid); end
        step();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_new_end got %0b want 0", code_valid); end
    endtask

    task automatic test_random();
        int q[$];
        logic [3:0] v;
        int budget;
        for (int n = 0; n < 40; n++) begin
            v = 4'($urandom_range(0, 15));
            expected_codes(v, q);
            req = v; req_valid = 1'b1; code_ready = 1'($urandom_range(0, 1));
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd_accept_ready got %0b want 1 vec %b", req_ready, v); end
            step();
            budget = 200;
            while (q.size() > 0 && budget > 0) begin
                // Junk on the request side must be ignored while draining.
                req = 4'($urandom_range(0, 15));
                req_valid = 1'($urandom_range(0, 1));
                code_ready = 1'($urandom_range(0, 1));
                checks++; if (code_valid !== 1'b1 || int'(code) !== q[0]) begin errors++; $display("FAIL rnd_code got %0d/v%0b want %0d/v1 vec %b", code, code_valid, q[0], v); end
                checks++; if (code_last !== (q.size() == 1)) begin errors++; $display("FAIL rnd_last got %0b want %0b vec %b", code_last, (q.size() == 1), v); end
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rnd_drain_ready got %0b want 0 vec %b", req_ready, v); end
                if (code_ready) void'(q.pop_front());
                step();
                budget--;
            end
            if (budget == 0) begin
                checks++; errors++;
                $display("FAIL rnd_budget expired with %0d codes left, want 0", q.size());
            end
            req_valid = 1'b0;
            checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rnd_end_valid got %0b want 0 vec %b", code_valid, v); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd_end_ready got %0b want 1 vec %b", req_ready, v); end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_full_vector();
        test_backpressure();
        test_zero_vector();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
